// File: rtl/csr_file_pkg.sv
// Shared CSR definitions: data/address widths, CSR address map and the
// state encoding of the speculative write buffer.
package csr_file_pkg;

    localparam int CSR_WIDTH_DEF     = 64;
    localparam int CSR_WIDTH_LOG_DEF = 12;

    // Architectural counters and scratch registers are always 64 bits wide.
    localparam int CSR_REG_W = 64;

    localparam logic [11:0] CSR_FFLAGS   = 12'h001;
    localparam logic [11:0] CSR_FRM      = 12'h002;
    localparam logic [11:0] CSR_FCSR     = 12'h003;
    localparam logic [11:0] CSR_CYCLE    = 12'hC00;
    localparam logic [11:0] CSR_TIME     = 12'hC01;
    localparam logic [11:0] CSR_INSTRET  = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
    localparam logic [11:0] CSR_TIMEH    = 12'hC81;
    localparam logic [11:0] CSR_INSTRETH = 12'hC82;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;

    typedef enum logic [0:0] {
        EMPTY   = 1'b0,
        PENDING = 1'b1
    } wb_state_e;

endpackage

// File: rtl/csr_wr_buffer.sv
// One-entry speculative CSR write buffer. A write from the control ALU is
// parked here until its instruction commits; a flush discards it.
module csr_wr_buffer
    import csr_file_pkg::*;
#(
    parameter int ADDR_W = CSR_WIDTH_LOG_DEF,
    parameter int DATA_W = CSR_WIDTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              commit,
    input  logic              recover,
    output logic              pending,
    output logic              drop,
    output logic              apply_en,
    output logic [ADDR_W-1:0] apply_addr,
    output logic [DATA_W-1:0] apply_data
);

    wb_state_e         state_r;
    wb_state_e         state_next_s;
    logic              load_s;
    logic              clear_s;
    logic              drop_next_s;
    logic              apply_s;
    logic              drop_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] data_r;

    // Next-state and control decode; the committing entry is older than a
    // same-cycle flush, so it is applied before the buffer is cleared.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        clear_s      = 1'b0;
        drop_next_s  = 1'b0;
        apply_s      = 1'b0;
        case (state_r)
            EMPTY: begin
                if (recover) begin
                    state_next_s = EMPTY;
                    clear_s      = 1'b1;
                end else if (wr_en) begin
                    state_next_s = PENDING;
                    load_s       = 1'b1;
                end else begin
                    state_next_s = EMPTY;
                end
            end
            PENDING: begin
                apply_s = commit;
                if (recover) begin
                    state_next_s = EMPTY;
                    clear_s      = 1'b1;
                end else if (commit && wr_en) begin
                    state_next_s = PENDING;
                    load_s       = 1'b1;
                end else if (commit) begin
                    state_next_s = EMPTY;
                    clear_s      = 1'b1;
                end else if (wr_en) begin
                    state_next_s = PENDING;
                    drop_next_s  = 1'b1;
                end else begin
                    state_next_s = PENDING;
                end
            end
            default: begin
                state_next_s = EMPTY;
                clear_s      = 1'b1;
            end
        endcase
    end

    // FSM state and one-cycle drop pulse register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= EMPTY;
            drop_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            drop_r  <= drop_next_s;
        end
    end

    // Buffered entry payload; zeroed whenever the buffer empties.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_r <= {ADDR_W{1'b0}};
            data_r <= {DATA_W{1'b0}};
        end else if (load_s) begin
            addr_r <= wr_addr;
            data_r <= wr_data;
        end else if (clear_s) begin
            addr_r <= {ADDR_W{1'b0}};
            data_r <= {DATA_W{1'b0}};
        end else begin
            addr_r <= addr_r;
            data_r <= data_r;
        end
    end

    assign pending    = (state_r == PENDING);
    assign drop       = drop_r;
    assign apply_en   = apply_s;
    assign apply_addr = addr_r;
    assign apply_data = data_r;

endmodule

// File: rtl/csr_file.sv
// CSR register file: architectural counters, FP flags/rounding mode and
// mscratch, with writes staged through a one-entry commit buffer.
module csr_file
    import csr_file_pkg::*;
#(
    parameter int CSR_WIDTH     = CSR_WIDTH_DEF,
    parameter int CSR_WIDTH_LOG = CSR_WIDTH_LOG_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [CSR_WIDTH_LOG-1:0] csrRdAddr_i,
    output logic [CSR_WIDTH-1:0]     csrRdData_o,
    input  logic                     csrWrEn_i,
    input  logic [CSR_WIDTH_LOG-1:0] csrWrAddr_i,
    input  logic [CSR_WIDTH-1:0]     csrWrData_i,
    input  logic                     commitCsr_i,
    input  logic                     recoverFlag_i,
    input  logic [2:0]               commitCount_i,
    input  logic                     fflagsAccEn_i,
    input  logic [4:0]               fflagsAcc_i,
    output logic                     csrPending_o,
    output logic                     csrWrDrop_o
);

    logic                     apply_en_s;
    logic [CSR_WIDTH_LOG-1:0] apply_addr_s;
    logic [CSR_WIDTH-1:0]     apply_data_s;

    logic [11:0]          wr_addr_s;
    logic [11:0]          rd_addr_s;
    logic [CSR_REG_W-1:0] wr_val_s;
    logic [CSR_REG_W-1:0] rd_val_s;

    logic                 wr_fflags_s;
    logic                 wr_frm_s;
    logic                 wr_mscratch_s;
    logic [4:0]           new_fflags_s;
    logic [2:0]           new_frm_s;
    logic [4:0]           fflags_base_s;
    logic [4:0]           fflags_next_s;

    logic [CSR_REG_W-1:0] cycle_r;
    logic [CSR_REG_W-1:0] instret_r;
    logic [4:0]           fflags_r;
    logic [2:0]           frm_r;
    logic [CSR_REG_W-1:0] mscratch_r;

    csr_wr_buffer #(
        .ADDR_W (CSR_WIDTH_LOG),
        .DATA_W (CSR_WIDTH)
    ) u_wr_buffer (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (csrWrEn_i),
        .wr_addr    (csrWrAddr_i),
        .wr_data    (csrWrData_i),
        .commit     (commitCsr_i),
        .recover    (recoverFlag_i),
        .pending    (csrPending_o),
        .drop       (csrWrDrop_o),
        .apply_en   (apply_en_s),
        .apply_addr (apply_addr_s),
        .apply_data (apply_data_s)
    );

    assign wr_addr_s = 12'(apply_addr_s);
    assign rd_addr_s = 12'(csrRdAddr_i);
    assign wr_val_s  = CSR_REG_W'(apply_data_s);

    // Decode the committing write; counters and unmapped addresses are inert.
    always_comb begin
        wr_fflags_s   = 1'b0;
        wr_frm_s      = 1'b0;
        wr_mscratch_s = 1'b0;
        new_fflags_s  = wr_val_s[4:0];
        new_frm_s     = wr_val_s[2:0];
        if (apply_en_s) begin
            case (wr_addr_s)
                CSR_FFLAGS:   wr_fflags_s = 1'b1;
                CSR_FRM:      wr_frm_s    = 1'b1;
                CSR_FCSR: begin
                    wr_fflags_s = 1'b1;
                    wr_frm_s    = 1'b1;
                    new_frm_s   = wr_val_s[7:5];
                end
                CSR_MSCRATCH: wr_mscratch_s = 1'b1;
                default:      wr_mscratch_s = 1'b0;
            endcase
        end else begin
            wr_mscratch_s = 1'b0;
        end
    end

    // fflags merges the committed value with same-cycle FP exception accrual.
    always_comb begin
        fflags_base_s = fflags_r;
        if (wr_fflags_s) begin
            fflags_base_s = new_fflags_s;
        end else begin
            fflags_base_s = fflags_r;
        end
        if (fflagsAccEn_i) begin
            fflags_next_s = fflags_base_s | fflagsAcc_i;
        end else begin
            fflags_next_s = fflags_base_s;
        end
    end

    // Architectural state update: free-running counters plus committed writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_r    <= {CSR_REG_W{1'b0}};
            instret_r  <= {CSR_REG_W{1'b0}};
            fflags_r   <= 5'd0;
            frm_r      <= 3'd0;
            mscratch_r <= {CSR_REG_W{1'b0}};
        end else begin
            cycle_r   <= cycle_r + 64'd1;
            instret_r <= instret_r + {61'd0, commitCount_i};
            fflags_r  <= fflags_next_s;
            if (wr_frm_s) begin
                frm_r <= new_frm_s;
            end else begin
                frm_r <= frm_r;
            end
            if (wr_mscratch_s) begin
                mscratch_r <= wr_val_s;
            end else begin
                mscratch_r <= mscratch_r;
            end
        end
    end

    // Read mux over committed state only; the buffered write is not visible.
    always_comb begin
        rd_val_s = {CSR_REG_W{1'b0}};
        case (rd_addr_s)
            CSR_FFLAGS:              rd_val_s = {59'd0, fflags_r};
            CSR_FRM:                 rd_val_s = {61'd0, frm_r};
            CSR_FCSR:                rd_val_s = {56'd0, frm_r, fflags_r};
            CSR_CYCLE, CSR_TIME:     rd_val_s = cycle_r;
            CSR_INSTRET:             rd_val_s = instret_r;
            CSR_CYCLEH, CSR_TIMEH:   rd_val_s = {32'd0, cycle_r[63:32]};
            CSR_INSTRETH:            rd_val_s = {32'd0, instret_r[63:32]};
            CSR_MSCRATCH:            rd_val_s = mscratch_r;
            default:                 rd_val_s = {CSR_REG_W{1'b0}};
        endcase
    end

    assign csrRdData_o = CSR_WIDTH'(rd_val_s);

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: directed scenarios followed by random
// traffic, all compared against a behavioural model of the CSR rules.
module tb_csr_file;

    logic        clk;
    logic        reset;
    logic [11:0] csrRdAddr_i;
    logic [63:0] csrRdData_o;
    logic        csrWrEn_i;
    logic [11:0] csrWrAddr_i;
    logic [63:0] csrWrData_i;
    logic        commitCsr_i;
    logic        recoverFlag_i;
    logic [2:0]  commitCount_i;
    logic        fflagsAccEn_i;
    logic [4:0]  fflagsAcc_i;
    logic        csrPending_o;
    logic        csrWrDrop_o;

    int n_assert;
    int n_fail;

    typedef struct {
        logic [11:0] a;
        logic [63:0] d;
    } ent_t;

    ent_t        buf_q[$];
    logic [63:0] m_cycle;
    logic [63:0] m_instret;
    logic [4:0]  m_fflags;
    logic [2:0]  m_frm;
    logic [63:0] m_mscratch;
    logic        m_drop;

    logic [11:0] addr_list [12] = '{12'h001, 12'h002, 12'h003, 12'hC00,
                                    12'hC01, 12'hC02, 12'hC80, 12'hC81,
                                    12'hC82, 12'h340, 12'h123, 12'h7FF};

    csr_file #(
        .CSR_WIDTH     (64),
        .CSR_WIDTH_LOG (12)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .csrRdAddr_i   (csrRdAddr_i),
        .csrRdData_o   (csrRdData_o),
        .csrWrEn_i     (csrWrEn_i),
        .csrWrAddr_i   (csrWrAddr_i),
        .csrWrData_i   (csrWrData_i),
        .commitCsr_i   (commitCsr_i),
        .recoverFlag_i (recoverFlag_i),
        .commitCount_i (commitCount_i),
        .fflagsAccEn_i (fflagsAccEn_i),
        .fflagsAcc_i   (fflagsAcc_i),
        .csrPending_o  (csrPending_o),
        .csrWrDrop_o   (csrWrDrop_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_read(input logic [11:0] a);
        case (a)
            12'h001:          return 64'(m_fflags);
            12'h002:          return 64'(m_frm);
            12'h003:          return 64'(m_frm) * 64'd32 + 64'(m_fflags);
            12'hC00, 12'hC01: return m_cycle;
            12'hC02:          return m_instret;
            12'hC80, 12'hC81: return m_cycle >> 32;
            12'hC82:          return m_instret >> 32;
            12'h340:          return m_mscratch;
            default:          return 64'd0;
        endcase
    endfunction

    task automatic model_reset();
        buf_q.delete();
        m_cycle    = 64'd0;
        m_instret  = 64'd0;
        m_fflags   = 5'd0;
        m_frm      = 3'd0;
        m_mscratch = 64'd0;
        m_drop     = 1'b0;
    endtask

    // One clock of the architectural rules, using the inputs now applied.
    task automatic model_update();
        ent_t       e;
        logic [4:0] ff;
        ff     = m_fflags;
        m_drop = 1'b0;
        if (commitCsr_i && buf_q.size() != 0) begin
            e = buf_q.pop_front();
            if (e.a == 12'h001) ff = e.d[4:0];
            if (e.a == 12'h002) m_frm = e.d[2:0];
            if (e.a == 12'h003) begin
                ff    = e.d[4:0];
                m_frm = e.d[7:5];
            end
            if (e.a == 12'h340) m_mscratch = e.d;
        end
        m_fflags = ff | (fflagsAccEn_i ? fflagsAcc_i : 5'd0);
        if (recoverFlag_i) begin
            buf_q.delete();
        end else if (csrWrEn_i) begin
            if (buf_q.size() == 0) begin
                e.a = csrWrAddr_i;
                e.d = csrWrData_i;
                buf_q.push_back(e);
            end else begin
                m_drop = 1'b1;
            end
        end
        m_cycle   = m_cycle + 64'd1;
        m_instret = m_instret + 64'(commitCount_i);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_update();
        #1;
        check({tag, ":pending"}, 64'(csrPending_o), 64'(buf_q.size() != 0));
        check({tag, ":drop"}, 64'(csrWrDrop_o), 64'(m_drop));
        check({tag, ":rd"}, csrRdData_o, model_read(csrRdAddr_i));
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        csrWrEn_i     = 1'b0;
        csrWrAddr_i   = 12'h000;
        csrWrData_i   = 64'd0;
        commitCsr_i   = 1'b0;
        recoverFlag_i = 1'b0;
        commitCount_i = 3'd0;
        fflagsAccEn_i = 1'b0;
        fflagsAcc_i   = 5'd0;
    endtask

    task automatic put_wr(input logic [11:0] a, input logic [63:0] d);
        csrWrEn_i   = 1'b1;
        csrWrAddr_i = a;
        csrWrData_i = d;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        idle_inputs();
        csrRdAddr_i = 12'hC00;
        reset       = 1'b0;
        model_reset();

        // Reset state
        #2;
        check("rst:pending", 64'(csrPending_o), 64'd0);
        check("rst:drop", 64'(csrWrDrop_o), 64'd0);
        check("rst:cycle", csrRdData_o, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Cycle counts from 1 after the first edge out of reset
        step("first_edge");
        check("first_edge:cycle", csrRdData_o, 64'd1);

        // Write-then-commit on mscratch
        csrRdAddr_i = 12'h340;
        put_wr(12'h340, 64'h0000_0000_DEAD_BEEF);
        step("wtc_wr");
        idle_inputs();
        step("wtc_w1");
        step("wtc_w2");
        commitCsr_i = 1'b1;
        #1;
        check("wtc:before_commit", csrRdData_o, 64'd0);
        step("wtc_commit");
        idle_inputs();
        check("wtc:after_commit", csrRdData_o, 64'h0000_0000_DEAD_BEEF);

        // Flush discards the buffered frm write
        csrRdAddr_i = 12'h002;
        put_wr(12'h002, 64'd5);
        step("flush_wr");
        idle_inputs();
        recoverFlag_i = 1'b1;
        step("flush_rec");
        check("flush:pending", 64'(csrPending_o), 64'd0);
        idle_inputs();
        commitCsr_i = 1'b1;
        step("flush_commit");
        idle_inputs();
        check("flush:frm", csrRdData_o, 64'd0);

        // Overflow: second request without commit is dropped
        csrRdAddr_i = 12'h340;
        put_wr(12'h340, 64'h111);
        step("ovf_wr1");
        put_wr(12'h340, 64'h222);
        step("ovf_wr2");
        check("ovf:drop_pulse", 64'(csrWrDrop_o), 64'd1);
        idle_inputs();
        step("ovf_idle");
        check("ovf:drop_end", 64'(csrWrDrop_o), 64'd0);
        commitCsr_i = 1'b1;
        step("ovf_commit");
        idle_inputs();
        check("ovf:survivor", csrRdData_o, 64'h111);

        // Overlap: write together with commit is held, no drop
        put_wr(12'h340, 64'h333);
        step("ovl_wr1");
        put_wr(12'h340, 64'h444);
        commitCsr_i = 1'b1;
        step("ovl_wr2");
        check("ovl:first_applied", csrRdData_o, 64'h333);
        check("ovl:no_drop", 64'(csrWrDrop_o), 64'd0);
        check("ovl:held", 64'(csrPending_o), 64'd1);
        idle_inputs();
        commitCsr_i = 1'b1;
        step("ovl_commit2");
        idle_inputs();
        check("ovl:second_applied", csrRdData_o, 64'h444);

        // fflags merge with same-cycle accrual
        csrRdAddr_i = 12'h001;
        put_wr(12'h002, 64'd3);
        step("ff_frm_wr");
        idle_inputs();
        commitCsr_i = 1'b1;
        step("ff_frm_commit");
        idle_inputs();
        put_wr(12'h001, 64'h01);
        step("ff_wr");
        idle_inputs();
        commitCsr_i   = 1'b1;
        fflagsAccEn_i = 1'b1;
        fflagsAcc_i   = 5'h10;
        step("ff_merge");
        idle_inputs();
        check("ff:fflags", csrRdData_o, 64'h11);
        csrRdAddr_i = 12'h003;
        #1;
        check("ff:fcsr", csrRdData_o, 64'h71);

        // Counter writes are ignored
        put_wr(12'hC00, 64'd7);
        step("ro_wr");
        idle_inputs();
        commitCsr_i = 1'b1;
        csrRdAddr_i = 12'hC00;
        step("ro_commit");
        idle_inputs();

        // instret accumulates commitCount
        csrRdAddr_i   = 12'hC02;
        commitCount_i = 3'd4;
        repeat (3) step("instret_acc");
        idle_inputs();
        check("instret:12", csrRdData_o, 64'd12);

        // instret high word
        force dut.instret_r = 64'h0000_0001_0000_0000;
        #1;
        release dut.instret_r;
        m_instret   = 64'h0000_0001_0000_0000;
        csrRdAddr_i = 12'hC82;
        #1;
        check("instreth:one", csrRdData_o, 64'd1);
        step("instreth_step");

        // cycle wraps modulo 2^64
        force dut.cycle_r = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.cycle_r;
        m_cycle     = 64'hFFFF_FFFF_FFFF_FFFF;
        csrRdAddr_i = 12'hC00;
        step("cycle_wrap");
        check("cycle:wrap", csrRdData_o, 64'd0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            csrWrEn_i     = 1'($urandom_range(1, 0));
            csrWrAddr_i   = addr_list[$urandom_range(11, 0)];
            csrWrData_i   = {$urandom, $urandom};
            commitCsr_i   = 1'($urandom_range(1, 0));
            recoverFlag_i = ($urandom_range(9, 0) == 0);
            commitCount_i = 3'($urandom_range(4, 0));
            fflagsAccEn_i = ($urandom_range(3, 0) == 0);
            fflagsAcc_i   = 5'($urandom);
            csrRdAddr_i   = addr_list[$urandom_range(11, 0)];
            step("rand");
        end
        idle_inputs();

        // Async reset while an entry is pending
        csrRdAddr_i = 12'h340;
        put_wr(12'h340, 64'h5555);
        step("ar_wr");
        idle_inputs();
        #2;
        reset = 1'b0;
        #1;
        check("ar:pending", 64'(csrPending_o), 64'd0);
        check("ar:drop", 64'(csrWrDrop_o), 64'd0);
        check("ar:mscratch", csrRdData_o, 64'd0);
        csrRdAddr_i = 12'hC00;
        #1;
        check("ar:cycle", csrRdData_o, 64'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        commitCsr_i = 1'b1;
        step("ar_release");
        idle_inputs();
        check("ar:cycle_one", csrRdData_o, 64'd1);
        csrRdAddr_i = 12'h340;
        #1;
        check("ar:no_write", csrRdData_o, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 SHALL have parameter CSR_WIDTH, default 64, CSR data width.
REQ-002 SHALL have parameter CSR_WIDTH_LOG, default 12, CSR address width.
REQ-003 SHALL have one clock and an asynchronous, active-low reset, named as the codebase does: clk  in  1  clock; reset  in  1  async active-low reset.
REQ-004 SHALL have the following ports:
- csrRdAddr_i  in  CSR_WIDTH_LOG  read address.
- csrRdData_o  out  CSR_WIDTH  read data, combinational.
- csrWrEn_i  in  1  speculative write request from the control ALU.
- csrWrAddr_i  in  CSR_WIDTH_LOG  write address.
- csrWrData_i  in  CSR_WIDTH  write data.
- commitCsr_i  in  1  the oldest CSR instruction retires.
- recoverFlag_i  in  1  pipeline flush.
- commitCount_i  in  3  instructions retired this cycle, 0..4.
- fflagsAccEn_i  in  1  FP exception accrual valid.
- fflagsAcc_i  in  5  accrued FP flags.
- csrPending_o  out  1  write buffer occupied; issue of CSR instructions stalls.
- csrWrDrop_o  out  1  one-cycle pulse when a request is lost.

Function
REQ-005 SHALL hold architectural registers: cycle[63:0], instret[63:0], fflags[4:0], frm[2:0], mscratch[63:0].
REQ-006 Read decode SHALL be:
- 0x001 fflags; 0x002 frm; 0x003 {frm,fflags}.
- 0xC00 and 0xC01 cycle; 0xC02 instret.
- 0xC80 and 0xC81 cycle[63:32]; 0xC82 instret[63:32].
- 0x340 mscratch.
- All narrower values zero-extended; any other address reads 0.
REQ-007 Reads SHALL see committed state only; the buffered write is not bypassed.
REQ-008 SHALL contain a one-entry write buffer with FSM states EMPTY and PENDING; csrPending_o = (state==PENDING).
REQ-009 EMPTY with csrWrEn_i SHALL capture addr/data and go to PENDING at the next edge.
REQ-010 PENDING with commitCsr_i SHALL apply the buffered write at that edge and go to EMPTY.
REQ-011 PENDING with commitCsr_i and csrWrEn_i in the same cycle SHALL apply the old entry, capture the new one, and stay PENDING.
REQ-012 PENDING with csrWrEn_i and no commitCsr_i SHALL keep the old entry, discard the new request, and pulse csrWrDrop_o the next cycle.
REQ-013 recoverFlag_i SHALL clear the buffer to EMPTY without writing.
REQ-014 recoverFlag_i with commitCsr_i in the same cycle SHALL apply the write first, since the committing instruction is older; any same-cycle csrWrEn_i is discarded without a drop pulse.
REQ-015 commitCsr_i in EMPTY SHALL be ignored.
REQ-016 Writes to 0xC00-0xC02 and 0xC80-0xC82 SHALL be ignored.
REQ-017 Writes to unmapped addresses SHALL be ignored.
REQ-018 A write to 0x003 SHALL set frm=data[7:5] and fflags=data[4:0].
REQ-019 cycle SHALL increment by 1 every cycle out of reset; instret SHALL add commitCount_i each cycle; both wrap modulo 2^64.
REQ-020 fflags next value SHALL be (committed write value if one targets 0x001/0x003, else current) OR (fflagsAccEn_i ? fflagsAcc_i : 0).
REQ-021 Write latency SHALL be 1 cycle from the commitCsr_i edge: a read in the following cycle returns the new value.

Reset
REQ-022 On reset low, asynchronously: state=EMPTY; all registers and buffer contents 0; csrPending_o=0; csrWrDrop_o=0.
REQ-023 Reset asserted mid-PENDING SHALL discard the entry with no write.
REQ-024 cycle SHALL first increment on the first rising edge after reset deasserts.

Structure
REQ-025 CSR address constants (FFLAGS, FRM, FCSR, CYCLE, TIME, INSTRET, CYCLEH, TIMEH, INSTRETH, MSCRATCH) and the FSM state enum SHALL live in the shared package beside the existing CSR_WIDTH definitions.
REQ-026 The write buffer plus FSM SHALL be a sub-module csr_wr_buffer; decode and registers SHALL stay in csr_file.

Verification
REQ-027 Write-then-commit: write 0x340=0xDEADBEEF, commit 3 cycles later -> csrRdData_o(0x340) reads 0 until the commit edge, 0xDEADBEEF the cycle after.
REQ-028 Flush: write 0x002=0x5, then recoverFlag_i -> frm stays 0, csrPending_o=0, a later commitCsr_i has no effect.
REQ-029 Overflow and overlap:
- Second write while PENDING without commit -> csrWrDrop_o pulses once and the first entry survives.
- Second write together with commit -> first entry applied, second held, no drop pulse.
REQ-030 fflags merge: commit write 0x001=0x01 with fflagsAccEn_i=1 and fflagsAcc_i=0x10 in the same cycle -> fflags=0x11; reading 0x003 with frm=3 returns 0x71.
REQ-031 Counters:
- Preload cycle=0xFFFFFFFF_FFFFFFFF via force -> next value 0.
- commitCount_i=4 for 3 cycles -> instret=12.
- Reading 0xC82 after instret=0x1_00000000 returns 1.
REQ-032 Async reset: assert reset between edges while PENDING -> all outputs 0 immediately; after release, cycle reads 1 after the first edge.
